// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle load/store unit between the RV32I core and a fixed-latency data SRAM
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses finish with err_o instead of being force-aligned.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LAT     = 1,
  parameter int WR_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  DM_OE,
  output logic [ADDR_WIDTH-1:0] DM_A,
  output logic [3:0]            DM_WEB,
  output logic [31:0]           DM_DI,
  input  logic [31:0]           DM_DO
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;
  logic        is_byte;
  logic        is_half;
  logic        misalign;
  logic [3:0]  mask_n;
  logic [31:0] di_n;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH+2];

  // funct3[1:0] alone selects the size; reserved encodings fall into the word case
  assign is_byte = (funct3_i[1:0] == 2'b00);
  assign is_half = (funct3_i[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign misalign = is_half ? addr_i[0] : (!is_byte && (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    mask_n = 4'h0;
    di_n   = wdata_i;
    if (is_byte) begin
      mask_n = ~(4'b0001 << addr_i[1:0]);
      di_n   = {24'h0, wdata_i[7:0]} << {addr_i[1:0], 3'b000};
    end else if (is_half) begin
      mask_n = addr_i[1] ? 4'b0011 : 4'b1100;
      di_n   = addr_i[1] ? {wdata_i[15:0], 16'h0} : {16'h0, wdata_i[15:0]};
    end
  end

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = lane[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (misalign)  next_state = DONE;
          else if (we_i) next_state = WR_WAIT;
          else           next_state = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt == 3'd0) next_state = DONE;
      WR_WAIT: if (cnt == 3'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall_o = (state == RD_WAIT) || (state == WR_WAIT) || ((state == IDLE) && req_i);
    done_o  = (state == DONE);
`ifdef MISALIGN_TRAP_EN
    err_o   = (state == DONE) && err_q;
`else
    err_o   = 1'b0;
`endif
  end

  // SRAM strobes are flops loaded from next_state so they hold exactly the wait-state cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 3'd0;
      lat_funct3 <= 3'd0;
      lat_lane   <= 2'd0;
      rdata_o    <= 32'h0;
      DM_OE      <= 1'b0;
      DM_A       <= '0;
      DM_WEB     <= 4'hF;
      DM_DI      <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_i) begin
        cnt        <= we_i ? 3'(WR_LAT - 1) : 3'(RD_LAT - 1);
        lat_funct3 <= funct3_i;
        lat_lane   <= addr_i[1:0];
`ifdef MISALIGN_TRAP_EN
        err_q      <= misalign;
`endif
      end else if ((state == RD_WAIT || state == WR_WAIT) && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end

      DM_OE <= (next_state == RD_WAIT);

      if (state == IDLE && (next_state == RD_WAIT || next_state == WR_WAIT))
        DM_A <= addr_i[ADDR_WIDTH+1:2];
      else if (next_state != RD_WAIT && next_state != WR_WAIT)
        DM_A <= '0;

      if (state == IDLE && next_state == WR_WAIT) begin
        DM_WEB <= mask_n;
        DM_DI  <= di_n;
      end else if (next_state != WR_WAIT) begin
        DM_WEB <= 4'hF;
        DM_DI  <= 32'h0;
      end

      if (state == RD_WAIT && cnt == 3'd0)
        rdata_o <= load_ext(DM_DO, lat_funct3, lat_lane);
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl (RD_LAT=3, WR_LAT=2)
module tb_lsu_mem_ctrl;
  localparam int AW = 14;
  localparam int RL = 3;
  localparam int WL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [2:0]    funct3_i = 3'd0;
  logic [31:0]   addr_i = 32'h0;
  logic [31:0]   wdata_i = 32'h0;
  logic [31:0]   DM_DO = 32'h0;
  logic          stall_o, done_o, err_o, DM_OE;
  logic [31:0]   rdata_o, DM_DI;
  logic [AW-1:0] DM_A;
  logic [3:0]    DM_WEB;

  lsu_mem_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .DM_OE(DM_OE), .DM_A(DM_A),
    .DM_WEB(DM_WEB), .DM_DI(DM_DI), .DM_DO(DM_DO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  web;
    logic [31:0] di;
    logic [31:0] rdata;
    logic        err;
    int          oe_n;
    int          we_n;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          oe_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] model_last = 32'h0;
  bit          prev_held = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_web(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100:
        case (a[1:0])
          2'd0: exp_web = 4'b1110;
          2'd1: exp_web = 4'b1101;
          2'd2: exp_web = 4'b1011;
          default: exp_web = 4'b0111;
        endcase
      3'b001, 3'b101: exp_web = a[1] ? 4'b0011 : 4'b1100;
      default: exp_web = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_di(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] wd);
    logic [3:0]  w;
    logic [31:0] m;
    logic [31:0] rep;
    w = exp_web(f3, a);
    for (int i = 0; i < 4; i++) m[8*i +: 8] = w[i] ? 8'h00 : 8'hFF;
    case (f3)
      3'b000, 3'b100: rep = {4{wd[7:0]}};
      3'b001, 3'b101: rep = {2{wd[15:0]}};
      default:        rep = wd;
    endcase
    exp_di = rep & m;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  exp_load = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  exp_load = {24'h0, b};
      3'b001:  exp_load = h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  exp_load = {16'h0, h};
      default: exp_load = d;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b001, 3'b101: misaligned = a[0];
      3'b000, 3'b100: misaligned = 1'b0;
      default:        misaligned = (a[1:0] != 2'b00);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (DM_OE) begin
        oe_cnt++;
        if (sb.size() == 0) check_eq("oe_spurious", 32'd1, 32'd0);
        else begin
          check_eq("oe_addr", 32'(DM_A), sb[0].a);
          check_eq("oe_web_idle", 32'(DM_WEB), 32'hF);
        end
      end
      if (DM_WEB != 4'hF) begin
        we_cnt++;
        if (sb.size() == 0) check_eq("we_spurious", 32'd1, 32'd0);
        else begin
          check_eq("we_addr", 32'(DM_A), sb[0].a);
          check_eq("we_mask", 32'(DM_WEB), 32'(sb[0].web));
          check_eq("we_data", DM_DI, sb[0].di);
        end
      end
      if (done_o) begin
        check_eq("done_stall", 32'(stall_o), 32'd0);
        if (sb.size() == 0) check_eq("done_unexp", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check_eq("err", 32'(err_o), 32'(mon_e.err));
          check_eq("rdata", rdata_o, mon_e.rdata);
          check_eq("oe_cycles", oe_cnt, mon_e.oe_n);
          check_eq("we_cycles", we_cnt, mon_e.we_n);
        end
        oe_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic do_acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] dout, input bit hold);
    exp_t e;
    bit   mis;
    int   n;
    int   lat;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = misaligned(f3, a);
`endif
    e.a    = 32'(a[AW+1:2]);
    e.web  = exp_web(f3, a);
    e.di   = exp_di(f3, a, wd);
    e.err  = mis;
    e.oe_n = (!we && !mis) ? RL : 0;
    e.we_n = (we && !mis) ? WL : 0;
    if (!we && !mis) model_last = exp_load(f3, a, dout);
    e.rdata = model_last;
    lat = mis ? 2 : (we ? WL + 2 : RL + 2);
    sb.push_back(e);
    DM_DO = dout; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    #1 check_eq("stall_req", 32'(stall_o), prev_held ? 32'd0 : 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 40);
    check_eq("done_seen", 32'(done_o), 32'd1);
    check_eq("latency", n, lat - 1 + (prev_held ? 1 : 0));
    if (!hold) begin
      req_i = 1'b0;
      @(negedge clk);
    end
    prev_held = hold;
  endtask

  task automatic reset_mid_read();
    exp_t e;
    e.a = 32'(6'h18); e.web = 4'hF; e.di = 0; e.rdata = 0; e.err = 0; e.oe_n = RL; e.we_n = 0;
    sb.push_back(e);
    DM_DO = 32'h600D_F00D; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h60; req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_oe", 32'(DM_OE), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_oe", 32'(DM_OE), 32'd0);
    check_eq("rst_web", 32'(DM_WEB), 32'hF);
    check_eq("rst_addr", 32'(DM_A), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    req_i = 1'b0;
    sb.delete();
    oe_cnt = 0;
    we_cnt = 0;
    model_last = 32'h0;
    prev_held = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", 32'(done_o), 32'd0);
    check_eq("post_rst_rdata", rdata_o, 32'd0);
    check_eq("post_rst_stall", 32'(stall_o), 32'd0);
    check_eq("post_rst_oe", 32'(DM_OE), 32'd0);
  endtask

  logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_oe", 32'(DM_OE), 32'd0);
    check_eq("reset_web", 32'(DM_WEB), 32'hF);
    check_eq("reset_addr", 32'(DM_A), 32'd0);
    check_eq("reset_di", DM_DI, 32'd0);
    check_eq("reset_rdata", rdata_o, 32'd0);
    check_eq("reset_done", 32'(done_o), 32'd0);
    check_eq("reset_err", 32'(err_o), 32'd0);
    check_eq("reset_stall", 32'(stall_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_acc(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_acc(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_0000, 1'b0);
    do_acc(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_0000, 1'b0);
    do_acc(1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF_0000, 1'b0);
    do_acc(1'b0, 3'b101, 32'h12, 32'h0, 32'h80FF_0000, 1'b0);
    do_acc(1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_007F, 1'b0);
    do_acc(1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_8001, 1'b0);
    do_acc(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 1'b0);
    do_acc(1'b1, 3'b000, 32'h31, 32'h0000_00A5, 32'h0, 1'b0);
    do_acc(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_acc(1'b0, 3'b011, 32'h44, 32'h0, 32'h1122_3344, 1'b0);
    do_acc(1'b1, 3'b111, 32'h48, 32'h5566_7788, 32'h0, 1'b0);

    do_acc(1'b1, 3'b010, 32'h50, 32'h55AA_33CC, 32'h0, 1'b1);
    do_acc(1'b0, 3'b010, 32'h50, 32'h0, 32'h55AA_33CC, 1'b0);

    do_acc(1'b0, 3'b010, 32'h21, 32'h0, 32'h0102_0304, 1'b0);
    do_acc(1'b1, 3'b001, 32'h23, 32'h0000_BEEF, 32'h0, 1'b0);
    do_acc(1'b0, 3'b101, 32'h27, 32'h0, 32'hF00D_8421, 1'b0);

    for (int i = 0; i < 10; i++)
      do_acc(1'($urandom), f3_tab[$urandom_range(0, 4)], $urandom & 32'h0000_FFFF,
             $urandom, $urandom, 1'($urandom));
    if (prev_held) begin
      req_i = 1'b0;
      prev_held = 1'b0;
      @(negedge clk);
    end

    reset_mid_read();
    do_acc(1'b0, 3'b000, 32'h71, 32'h0, 32'h0000_9C00, 1'b0);

    repeat (5) @(negedge clk);
    check_eq("queue_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
